// File: rtl/gpio_block_packer_if.sv
// Handshake bundle for gpio_block_packer: session control, GPIO sampling and block stream.
// master = producer/consumer side (testbench or system), slave = the packer itself.
interface gpio_block_packer_if #(
    parameter int GPIO_W = 24
);
    logic              start;
    logic [GPIO_W-1:0] gpio_data;
    logic              gpio_strobe;
    logic [255:0]      blk_data;
    logic              blk_valid;
    logic              blk_ready;
    logic [3:0]        blk_idx;
    logic              blk_last;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start, gpio_data, gpio_strobe, blk_ready,
        input  blk_data, blk_valid, blk_idx, blk_last, busy, done, overflow
    );

    modport slave (
        input  start, gpio_data, gpio_strobe, blk_ready,
        output blk_data, blk_valid, blk_idx, blk_last, busy, done, overflow
    );
endinterface

// File: rtl/gpio_block_packer.sv
// Packs 16-bit GPIO slices into 256-bit blocks (first slice in MSBs) and streams them via a small FIFO.
// Optional GPIO_PACK_SYNC_EN: 2-flop synchronizer plus rising-edge strobe detect on the GPIO inputs.
module gpio_block_packer #(
    parameter int GPIO_W     = 24,
    parameter int SLICE_LO   = 8,
    parameter int NUM_BLKS   = 10,
    parameter int FIFO_DEPTH = 2
) (
    input logic              clk,
    input logic              rst,
    gpio_block_packer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t         state;
    logic [3:0]     slice_cnt;
    logic [3:0]     blk_cnt;
    logic [255:0]   asm_reg;
    logic [255:0]   blk_next;
    logic [15:0]    slice;
    logic           cap;
    logic           busy_q;
    logic           done_q;
    logic           ovf_q;

    logic [255:0]   fifo_data [FIFO_DEPTH];
    logic [3:0]     fifo_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0] count;
    logic           fifo_full;
    logic           head_valid;
    logic           push;
    logic           pop;
    logic           push_ok;

`ifdef GPIO_PACK_SYNC_EN
    logic [15:0] data_s1, data_s2, slice_r;
    logic        strobe_s1, strobe_s2, strobe_s3, cap_r;

    // Edge detect is registered so a capture lands three cycles after the strobe rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_s1   <= '0;
            data_s2   <= '0;
            slice_r   <= '0;
            strobe_s1 <= 1'b0;
            strobe_s2 <= 1'b0;
            strobe_s3 <= 1'b0;
            cap_r     <= 1'b0;
        end else begin
            data_s1   <= bus.gpio_data[SLICE_LO +: 16];
            data_s2   <= data_s1;
            slice_r   <= data_s2;
            strobe_s1 <= bus.gpio_strobe;
            strobe_s2 <= strobe_s1;
            strobe_s3 <= strobe_s2;
            cap_r     <= strobe_s2 & ~strobe_s3;
        end
    end

    assign slice = slice_r;
    assign cap   = cap_r;
`else
    assign slice = bus.gpio_data[SLICE_LO +: 16];
    assign cap   = bus.gpio_strobe;
`endif

    // Assembly word including the slice arriving this cycle; slot 0 sits at bits [255:240].
    always_comb begin
        blk_next = asm_reg;
        blk_next[{~slice_cnt, 4'b0000} +: 16] = slice;
    end

    assign head_valid = (count != '0);
    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign pop        = head_valid & bus.blk_ready;
    assign push       = (state == COLLECT) && cap && (slice_cnt == 4'd15);
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slice_cnt <= '0;
            blk_cnt   <= '0;
            asm_reg   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        slice_cnt <= '0;
                        blk_cnt   <= '0;
                        asm_reg   <= '0;
                        ovf_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cap) begin
                        slice_cnt <= slice_cnt + 4'd1;
                        if (slice_cnt == 4'd15) begin
                            asm_reg <= '0;
                            if (push_ok) begin
                                blk_cnt <= blk_cnt + 4'd1;
                                if (blk_cnt == 4'(NUM_BLKS - 1))
                                    state <= DRAIN;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end else begin
                            asm_reg <= blk_next;
                        end
                    end
                end
                DRAIN: begin
                    if (!head_valid) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data[wr_ptr] <= blk_next;
            fifo_idx[wr_ptr]  <= blk_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)
                count <= count + (PTR_W+1)'(1);
            else if (pop && !push_ok)
                count <= count - (PTR_W+1)'(1);
        end
    end

    assign bus.blk_valid = head_valid;
    assign bus.blk_data  = head_valid ? fifo_data[rd_ptr] : '0;
    assign bus.blk_idx   = head_valid ? fifo_idx[rd_ptr] : '0;
    assign bus.blk_last  = head_valid && (fifo_idx[rd_ptr] == 4'(NUM_BLKS - 1));
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_gpio_block_packer.sv
// Directed bench for gpio_block_packer (default build, synchronizer disabled).
module tb_gpio_block_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpio_block_packer_if #(.GPIO_W(24)) bus ();

    gpio_block_packer #(
        .GPIO_W(24), .SLICE_LO(8), .NUM_BLKS(10), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    localparam logic [255:0] BLK0 =
        256'h0000_0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int delivered = 0;
    int done_before;
    bit rand_ready = 1'b0;
    logic [255:0] exp_data [$];
    logic [3:0]   exp_idx  [$];

    function automatic logic [255:0] blk_of(input int first);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[255 - 16*i -: 16] = 16'(first + i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the FIFO head against the expected queue, then advance past the edge.
    task automatic cyc();
        if (rand_ready)
            bus.blk_ready = 1'($urandom_range(0, 1));
        if (bus.done === 1'b1)
            done_cnt++;
        if (bus.blk_valid === 1'b1) begin
            if (exp_data.size() == 0) begin
                chk("unexpected_block", bus.blk_valid, 0);
            end else begin
                chk("blk_data", bus.blk_data, exp_data[0]);
                chk("blk_idx", bus.blk_idx, exp_idx[0]);
                chk("blk_last", bus.blk_last, exp_idx[0] == 4'd9);
                if (bus.blk_ready) begin
                    void'(exp_data.pop_front());
                    void'(exp_idx.pop_front());
                    delivered++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic run_strobes(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            bus.gpio_data   = {16'(i), 8'hC3};
            bus.gpio_strobe = 1'b1;
            cyc();
        end
        bus.gpio_strobe = 1'b0;
    endtask

    task automatic expect_blocks(input int k_lo, input int k_hi, input int slice_ofs);
        for (int k = k_lo; k <= k_hi; k++) begin
            exp_data.push_back(blk_of(16*k + slice_ofs));
            exp_idx.push_back(4'(k));
        end
    endtask

    task automatic wait_done(input string tag);
        int base;
        base = done_cnt;
        for (int n = 0; n < 300 && done_cnt == base; n++)
            cyc();
        chk({tag, "_done_once"}, done_cnt - base, 1);
        chk({tag, "_queue_empty"}, exp_data.size(), 0);
        chk({tag, "_busy_end"}, bus.busy, 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.gpio_data   = '0;
        bus.gpio_strobe = 1'b0;
        bus.blk_ready   = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", bus.blk_valid, 0);
        chk("rst_data", bus.blk_data, 0);
        chk("rst_idx", bus.blk_idx, 0);
        chk("rst_last", bus.blk_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_overflow", bus.overflow, 0);
        rst = 1'b0;
        bus.gpio_strobe = 1'b1;
        cyc();
        bus.gpio_strobe = 1'b0;
        chk("idle_ignores_strobe_busy", bus.busy, 0);
        chk("idle_ignores_strobe_valid", bus.blk_valid, 0);

        // Nominal session, start re-pulsed at slice 5, exact latency and done timing.
        bus.blk_ready = 1'b1;
        expect_blocks(0, 9, 0);
        start_pulse();
        chk("nom_busy", bus.busy, 1);
        for (int i = 0; i < 160; i++) begin
            if (i == 5)  bus.start = 1'b1;
            if (i == 15) chk("nom_latency_pre", bus.blk_valid, 0);
            if (i == 16) begin
                chk("nom_blk0_valid", bus.blk_valid, 1);
                chk("nom_blk0_literal", bus.blk_data, BLK0);
            end
            bus.gpio_data   = {16'(i), 8'hC3};
            bus.gpio_strobe = 1'b1;
            cyc();
            bus.start = 1'b0;
            if (i == 5) chk("nom_start_ignored_busy", bus.busy, 1);
        end
        bus.gpio_strobe = 1'b0;
        chk("nom_last_valid", bus.blk_valid, 1);
        chk("nom_last_flag", bus.blk_last, 1);
        cyc();
        chk("nom_drain_done", bus.done, 0);
        chk("nom_drain_busy", bus.busy, 1);
        cyc();
        chk("nom_done_pulse", bus.done, 1);
        chk("nom_done_busy", bus.busy, 0);
        cyc();
        chk("nom_done_cleared", bus.done, 0);
        chk("nom_done_count", done_cnt, 1);
        chk("nom_delivered", delivered, 10);
        chk("nom_overflow", bus.overflow, 0);

        // Backpressure: third block dropped, block number 2 re-collected from slices 48..63.
        bus.blk_ready = 1'b0;
        expect_blocks(0, 1, 0);
        start_pulse();
        run_strobes(0, 47);
        chk("ovf_before_drop", bus.overflow, 0);
        run_strobes(47, 1);
        chk("ovf_set", bus.overflow, 1);
        chk("ovf_head_idx", bus.blk_idx, 0);
        chk("ovf_busy", bus.busy, 1);
        bus.blk_ready = 1'b1;
        expect_blocks(2, 9, 16);
        run_strobes(48, 128);
        wait_done("ovf");
        chk("ovf_sticky", bus.overflow, 1);

        // Random backpressure: head must match the model every valid cycle, stalled or not.
        rand_ready = 1'b1;
        expect_blocks(0, 9, 0);
        start_pulse();
        chk("rnd_overflow_cleared", bus.overflow, 0);
        run_strobes(0, 160);
        wait_done("rnd");
        chk("rnd_overflow", bus.overflow, 0);
        rand_ready = 1'b0;

        // Reset after 37 strobes with two blocks waiting in the FIFO.
        bus.blk_ready = 1'b0;
        expect_blocks(0, 1, 0);
        start_pulse();
        run_strobes(0, 37);
        done_before = done_cnt;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_data.delete();
        exp_idx.delete();
        chk("mid_rst_valid", bus.blk_valid, 0);
        chk("mid_rst_data", bus.blk_data, 0);
        chk("mid_rst_idx", bus.blk_idx, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_overflow", bus.overflow, 0);
        cyc();
        chk("mid_rst_no_done", done_cnt, done_before);
        bus.blk_ready = 1'b1;
        delivered = 0;
        expect_blocks(0, 9, 0);
        start_pulse();
        run_strobes(0, 160);
        wait_done("post_rst");
        chk("post_rst_delivered", delivered, 10);
        chk("post_rst_overflow", bus.overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
